// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the PicoRV32 two-master memory arbiter.
package picorv32_mem_pkg;

    localparam int unsigned MEM_AW = 32;
    localparam int unsigned MEM_DW = 32;
    localparam int unsigned MEM_SW = 4;
    localparam int unsigned TMR_W  = 16;

    localparam logic [MEM_DW-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              instr;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_SW-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv32_mem_arb_timer.sv
// Watchdog counter for a granted access; counts stalled grant cycles and
// flags the cycle in which the access must be forced to complete.
module picorv32_mem_arb_timer
    import picorv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic active,
    input  logic stall,
    output logic hit_c
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [TMR_W-1:0] timer;

            // Saturating stall counter, held at zero while no grant exists
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    timer <= '0;
                end else if (clear) begin
                    timer <= '0;
                end else if (active && stall && (timer != '1)) begin
                    timer <= timer + TMR_W'(1);
                end
            end

            assign hit_c = active && stall && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_off
            logic unused_c;
            assign unused_c = ^{clk, resetn, clear, active, stall};
            assign hit_c    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter sharing one PicoRV32 native memory port, one outstanding
// access at a time, with optional watchdog completion of hung accesses.
module picorv32_mem_arbiter
    import picorv32_mem_pkg::*;
#(
    parameter bit                ROUND_ROBIN    = 1'b1,
    parameter int unsigned       TIMEOUT_CYCLES = 0,
    parameter logic [MEM_DW-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [MEM_AW-1:0] m0_addr,
    input  logic [MEM_DW-1:0] m0_wdata,
    input  logic [MEM_SW-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [MEM_DW-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [MEM_AW-1:0] m1_addr,
    input  logic [MEM_DW-1:0] m1_wdata,
    input  logic [MEM_SW-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [MEM_DW-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [MEM_AW-1:0] s_addr,
    output logic [MEM_DW-1:0] s_wdata,
    output logic [MEM_SW-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [MEM_DW-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    arb_state_e state, state_d;
    logic       last_grant, last_grant_d;
    logic       tmr_clear_c, tmr_active_c, hit_c;
    mem_req_t   req0, req1, s_req;

    assign req0 = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign req1 = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    // Watchdog only runs while the owner keeps its request up
    assign tmr_clear_c  = (state == IDLE);
    assign tmr_active_c = ((state == GNT0) && m0_valid) || ((state == GNT1) && m1_valid);

    picorv32_mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tmr_clear_c),
        .active (tmr_active_c),
        .stall  (!s_ready),
        .hit_c  (hit_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        s_valid      = 1'b0;
        s_req        = '0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_rdata     = s_rdata;
        m1_rdata     = s_rdata;
        grant        = 2'b00;
        timeout_err  = 1'b0;

        case (state)
            IDLE: begin
                // On a tie, round-robin hands the port to whoever did not own it last
                if (m0_valid && m1_valid) begin
                    if (ROUND_ROBIN && (last_grant == 1'(M0))) begin
                        state_d      = GNT1;
                        last_grant_d = 1'(M1);
                    end else begin
                        state_d      = GNT0;
                        last_grant_d = 1'(M0);
                    end
                end else if (m0_valid) begin
                    state_d      = GNT0;
                    last_grant_d = 1'(M0);
                end else if (m1_valid) begin
                    state_d      = GNT1;
                    last_grant_d = 1'(M1);
                end
            end
            GNT0: begin
                s_req       = req0;
                s_valid     = m0_valid && !hit_c;
                m0_ready    = s_ready || hit_c;
                m0_rdata    = hit_c ? ERR_RDATA : s_rdata;
                grant[M0]   = 1'b1;
                timeout_err = hit_c;
                if (m0_ready || !m0_valid) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                s_req       = req1;
                s_valid     = m1_valid && !hit_c;
                m1_ready    = s_ready || hit_c;
                m1_rdata    = hit_c ? ERR_RDATA : s_rdata;
                grant[M1]   = 1'b1;
                timeout_err = hit_c;
                if (m1_ready || !m1_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_instr = s_req.instr;
    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wstrb = s_req.wstrb;

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
Two-master arbiter that shares one PicoRV32 native memory port (valid/instr/ready/addr/wdata/wstrb/rdata) between two requesters, e.g. a picorv32 core and a DMA/debug master, in front of the testbench or SoC memory model. It runs round-robin or fixed-priority arbitration with one outstanding transaction at a time. An optional watchdog completes a hung slave access with an error word.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin on simultaneous requests; 0 = master 0 always wins ties
TIMEOUT_CYCLES, 0, cycles in grant without s_ready before forced completion; 0 = watchdog disabled; max 65535
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on timeout

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
m0_valid / m1_valid  in  1  master request, held until its ready
m0_instr / m1_instr  in  1  instruction-fetch qualifier
m0_addr / m1_addr  in  32  byte address
m0_wdata / m1_wdata  in  32  write data
m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read
m0_ready / m1_ready  out  1  one-cycle completion pulse to the owning master
m0_rdata / m1_rdata  out  32  read data, valid only with the matching ready
s_valid  out  1  request to shared memory
s_instr  out  1  muxed instr
s_addr  out  32  muxed address
s_wdata  out  32  muxed write data
s_wstrb  out  4  muxed strobes
s_ready  in  1  memory completion
s_rdata  in  32  memory read data
grant  out  2  one-hot current owner; 00 when idle
timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Registered: state, last_grant, timer[15:0].
- Reset values: state=IDLE, last_grant=1 (master 0 wins the first tie), timer=0. All outputs 0: s_valid=0, s_* data=0, m*_ready=0, grant=00, timeout_err=0. m*_rdata=s_rdata combinationally.
- Asynchronous reset takes effect mid-transaction: s_valid drops immediately, and a late s_ready is ignored because no grant exists.
- IDLE transitions:
  - only mX_valid high -> GNTX next cycle.
  - both high, ROUND_ROBIN=1 -> grant the master != last_grant.
  - both high, ROUND_ROBIN=0 -> GNT0.
  - On entering GNTX, last_grant is set to X.
- GNTX outputs, combinational from state:
  - s_valid = mX_valid; s_instr/addr/wdata/wstrb = master X fields.
  - mX_ready = s_ready | timeout_hit; other master's ready = 0; grant = one-hot X.
- Latency: request first seen in IDLE at cycle N; s_valid at N+1; mX_ready in the same cycle as s_ready (zero added return latency).
- Completion: on mX_ready -> IDLE next cycle. There is one mandatory IDLE cycle between transactions, because picorv32 may keep valid high in its ready cycle.
- Abort: if mX_valid drops while in GNTX without ready (protocol violation) -> IDLE next cycle; no ready, no error.
- Watchdog, TIMEOUT_CYCLES>0:
  - timer clears on entering GNTX and increments each GNTX cycle with s_ready=0.
  - timeout_hit = (timer == TIMEOUT_CYCLES-1) & !s_ready.
  - On timeout_hit: mX_ready=1, mX_rdata=ERR_RDATA, timeout_err=1, s_valid forced 0 that cycle, -> IDLE.
  - s_ready and timeout_hit in the same cycle: s_ready wins (normal data, no error).
- Width rules: timer saturates at 16 bits; no address decode; strobes pass unmodified.
- Non-owner master: sees ready=0; its request stays pending and is arbitrated in the next IDLE.
- Starvation bound with ROUND_ROBIN=1: a pending master waits at most one foreign transaction.

Decomposition:
- Package picorv32_mem_pkg:
  - arb_state_e enum {IDLE, GNT0, GNT1}
  - MEM_AW=32, MEM_DW=32, MEM_SW=4
  - DEFAULT_ERR_RDATA
  - M0=0, M1=1 index constants
- One natural sub-module: picorv32_mem_arb_timer (clear/enable/hit watchdog counter, parameterised by TIMEOUT_CYCLES; tied off when 0).
- FSM and mux stay in the top.

Test Plan:
- Single read: m0 reads 0x0000_0010, memory answers 0x1234_5678 one cycle after s_valid -> s_valid at N+1, m0_ready pulse with m0_rdata=0x1234_5678, grant 01->00, m1_ready stays 0.
- Simultaneous requests: m0 and m1 raised at the same cycle, three times, ROUND_ROBIN=1 -> grants 0,1,0 with one IDLE cycle between each. With ROUND_ROBIN=0, both held high -> m0 is granted every time.
- Byte write: m1 writes 0xAABB_CCDD, wstrb=0010, to 0x100 -> s_wstrb=0010, s_addr=0x100, s_wdata=0xAABB_CCDD; memory word 0x40 byte1 becomes 0xCC, all other bytes unchanged.
- Timeout: TIMEOUT_CYCLES=8, slave never readies -> exactly 8 cycles after grant, m0_ready=1 with rdata=0xDEAD_BEEF and timeout_err pulse; the next request is serviced normally.
- Timeout race: s_ready arrives in the timeout cycle -> slave data returned, timeout_err=0.
- Reset mid-transaction: resetn low while in GNT1 with s_valid high -> s_valid=0 and grant=00 immediately. After release, a first tie goes to m0.
